// File: rtl/moving_average_filter.sv
// Boxcar moving-average filter over the last 2^LOG2_N accepted samples, with
// round-half-up, optional signed arithmetic, bypass and a fixed two-edge latency.
module moving_average_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG2_N = 6,
  parameter int unsigned SIGNED = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_data_avail,
  input  logic [DATA_W-1:0] i_data_byte,
  input  logic              i_clear,
  input  logic              i_bypass,
  output logic [DATA_W-1:0] o_data_byte,
  output logic              o_data_avail,
  output logic              o_full
);

  localparam int unsigned N     = 1 << LOG2_N;
  localparam int unsigned ACC_W = DATA_W + LOG2_N + 1;
  localparam logic [LOG2_N:0]  FILL_MAX = (LOG2_N + 1)'(N);
  localparam logic [ACC_W-1:0] HALF     = ACC_W'(1) << (LOG2_N - 1);

  logic [DATA_W-1:0] mem_q [N];
  logic              mem_we;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [LOG2_N:0]   fill_q, fill_d;
  logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_byp_q, s1_byp_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              full_q, full_d;

  logic              win_full;
  logic [DATA_W-1:0] oldest_eff;
  logic [ACC_W-1:0]  rounded;
  logic [DATA_W-1:0] avg;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
    if (SIGNED != 0) begin
      return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
    end else begin
      return {{(ACC_W - DATA_W){1'b0}}, v};
    end
  endfunction

  // Zero-padding during warm-up keeps the sum independent of stale buffer contents.
  assign win_full   = (fill_q == FILL_MAX);
  assign oldest_eff = win_full ? mem_q[wr_ptr_q] : '0;
  assign rounded    = acc_q + HALF;

  always_comb begin
    if (SIGNED != 0) begin
      avg = DATA_W'($signed(rounded) >>> LOG2_N);
    end else begin
      avg = DATA_W'(rounded >> LOG2_N);
    end
  end

  always_comb begin
    acc_d      = acc_q;
    fill_d     = fill_q;
    wr_ptr_d   = wr_ptr_q;
    s1_valid_d = 1'b0;
    s1_data_d  = s1_data_q;
    s1_byp_d   = s1_byp_q;
    mem_we     = 1'b0;
    if (i_clear) begin
      acc_d    = '0;
      fill_d   = '0;
      wr_ptr_d = '0;
    end else if (i_data_avail) begin
      acc_d      = acc_q + ext(i_data_byte) - ext(oldest_eff);
      mem_we     = 1'b1;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      fill_d     = win_full ? fill_q : fill_q + 1'b1;
      s1_valid_d = 1'b1;
      s1_data_d  = i_data_byte;
      s1_byp_d   = i_bypass;
    end
  end

  // Stage 2 reads the accumulator as it stood after the sample's own accept edge.
  always_comb begin
    out_valid_d = s1_valid_q;
    out_data_d  = out_data_q;
    if (s1_valid_q) begin
      out_data_d = s1_byp_q ? s1_data_q : avg;
    end
    full_d = (fill_d == FILL_MAX);
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= i_data_byte;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_byp_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_byp_q    <= s1_byp_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      full_q      <= full_d;
    end
  end

  assign o_data_byte  = out_data_q;
  assign o_data_avail = out_valid_q;
  assign o_full       = full_q;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: an unsigned and a signed N=4 instance,
// expected outputs queued at drive time and checked with their due cycle.
module tb_moving_average_filter;

  logic       clock;
  logic       reset_n;
  logic       u_avail, u_clear, u_bypass, u_oavail, u_full;
  logic [7:0] u_data, u_obyte;
  logic       s_avail, s_clear, s_bypass, s_oavail, s_full;
  logic [7:0] s_data, s_obyte;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t q_u[$];
  exp_t q_s[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  moving_average_filter #(.DATA_W(8), .LOG2_N(2), .SIGNED(0)) u_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_data_avail (u_avail),
    .i_data_byte  (u_data),
    .i_clear      (u_clear),
    .i_bypass     (u_bypass),
    .o_data_byte  (u_obyte),
    .o_data_avail (u_oavail),
    .o_full       (u_full)
  );

  moving_average_filter #(.DATA_W(8), .LOG2_N(2), .SIGNED(1)) s_dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_data_avail (s_avail),
    .i_data_byte  (s_data),
    .i_clear      (s_clear),
    .i_bypass     (s_bypass),
    .o_data_byte  (s_obyte),
    .o_data_avail (s_oavail),
    .o_full       (s_full)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set at a negedge; returns at the following negedge.
  task automatic send(input bit sel_s, input logic av, input logic [7:0] d, input logic clr,
                      input logic byp, input bit push, input logic [7:0] e);
    if (sel_s) begin
      s_avail = av; s_data = d; s_clear = clr; s_bypass = byp;
      if (push) q_s.push_back('{data: e, due: cyc + 2});
    end else begin
      u_avail = av; u_data = d; u_clear = clr; u_bypass = byp;
      if (push) q_u.push_back('{data: e, due: cyc + 2});
    end
    @(negedge clock);
    u_avail = 1'b0; u_clear = 1'b0; u_bypass = 1'b0;
    s_avail = 1'b0; s_clear = 1'b0; s_bypass = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (u_oavail === 1'b1) begin
      if (q_u.size() == 0) chk("u_unexpected_avail", 32'(u_oavail), 0);
      else begin
        e = q_u.pop_front();
        chk("u_data", 32'(u_obyte), 32'(e.data));
        chk("u_latency", cyc, e.due);
      end
    end
    if (s_oavail === 1'b1) begin
      if (q_s.size() == 0) chk("s_unexpected_avail", 32'(s_oavail), 0);
      else begin
        e = q_s.pop_front();
        chk("s_data", 32'(s_obyte), 32'(e.data));
        chk("s_latency", cyc, e.due);
      end
    end
  end

  initial begin
    logic [7:0] t2e [12];
    logic [7:0] t3d [8];
    logic [7:0] t3e [8];
    t2e = '{8'd64, 8'd128, 8'd191, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255,
            8'd191, 8'd128, 8'd64, 8'd0};
    t3d = '{8'hFC, 8'hFC, 8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFD, 8'hFE};
    t3e = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFC, 8'hFD, 8'hFD, 8'hFD};
    reset_n = 1'b0;
    u_avail = 1'b0; u_data = '0; u_clear = 1'b0; u_bypass = 1'b0;
    s_avail = 1'b0; s_data = '0; s_clear = 1'b0; s_bypass = 1'b0;

    #7;
    chk("rst_u_avail", 32'(u_oavail), 0);
    chk("rst_u_byte", 32'(u_obyte), 0);
    chk("rst_u_full", 32'(u_full), 0);
    chk("rst_s_avail", 32'(s_oavail), 0);
    #6 reset_n = 1'b1;
    @(negedge clock);

    // Warm-up and steady state
    send(0, 1, 8'd4, 0, 0, 1, 8'd1);
    send(0, 1, 8'd8, 0, 0, 1, 8'd3);
    send(0, 1, 8'd12, 0, 0, 1, 8'd6);
    chk("t1_full_before", 32'(u_full), 0);
    send(0, 1, 8'd16, 0, 0, 1, 8'd10);
    chk("t1_full_after", 32'(u_full), 1);
    send(0, 1, 8'd20, 0, 0, 1, 8'd14);
    idle(3);

    // Saturation and pointer wrap
    send(0, 0, 8'd0, 1, 0, 0, 8'd0);
    chk("t2_full_cleared", 32'(u_full), 0);
    for (int i = 0; i < 12; i++) send(0, 1, (i < 8) ? 8'd255 : 8'd0, 0, 0, 1, t2e[i]);
    idle(3);

    // Signed arithmetic
    for (int i = 0; i < 8; i++) send(1, 1, t3d[i], 0, 0, 1, t3e[i]);
    chk("t3_s_full", 32'(s_full), 1);
    idle(3);

    // Clear colliding with a strobe
    for (int i = 0; i < 4; i++) send(0, 1, 8'd100, 0, 0, 1, 8'(25 * (i + 1)));
    send(0, 1, 8'd40, 1, 0, 0, 8'd0);
    chk("t4_full_after_clear", 32'(u_full), 0);
    send(0, 1, 8'd40, 0, 0, 1, 8'd10);
    idle(3);

    // Bypass, then async reset with a sample in flight
    send(0, 0, 8'd0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 4; i++) send(0, 1, 8'd100, 0, 0, 1, 8'(25 * (i + 1)));
    send(0, 1, 8'd200, 0, 1, 1, 8'd200);
    send(0, 1, 8'd100, 0, 0, 1, 8'd125);
    send(0, 1, 8'd60, 0, 0, 0, 8'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_avail_in_reset", 32'(u_oavail), 0);
    chk("t6_byte_in_reset", 32'(u_obyte), 0);
    chk("t6_full_in_reset", 32'(u_full), 0);
    q_u.delete();
    @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    send(0, 1, 8'd8, 0, 0, 1, 8'd2);
    idle(4);

    chk("drain_u", q_u.size(), 0);
    chk("drain_s", q_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
